// File: rtl/ttl_sched_pkg.sv
// Shared constants and helpers for the TTL event scheduler.
// An event word carries a 64-bit timestamp above a 64-bit payload.
package ttl_sched_pkg;

  localparam int TS_W        = 64;
  localparam int WORD_W      = 128;
  localparam int PAYLOAD_MSB = 63;
  localparam int TS_LSB      = PAYLOAD_MSB + 1;

  function automatic logic [TS_W-1:0] ts_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1:TS_LSB];
  endfunction

endpackage

// File: rtl/ttl_min_ts_select.sv
// Earliest-timestamp selector: a balanced compare tree over the valid heads.
// Timestamp ties go to the requester closest at or after rr_ptr.
module ttl_min_ts_select
  import ttl_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [NUM_REQ*TS_W-1:0]    ts,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       any_valid,
  output logic [TS_W-1:0]            min_ts
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int P  = 1 << IW;

  always_comb begin : tree
    logic            nv   [1:2*P-1];
    logic [TS_W-1:0] nts  [1:2*P-1];
    logic [IW-1:0]   nidx [1:2*P-1];
    logic [IW-1:0]   npos [1:2*P-1];
    logic            take_r;
    int              d;

    for (int k = 1; k < 2*P; k++) begin
      nv[k]   = 1'b0;
      nts[k]  = '0;
      nidx[k] = '0;
      npos[k] = '0;
    end
    take_r = 1'b0;
    d      = 0;

    // Leaves carry their distance from rr_ptr so ties resolve round-robin.
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      nv[P+i]   = valid[i];
      nts[P+i]  = ts[i*TS_W +: TS_W];
      nidx[P+i] = i[IW-1:0];
      npos[P+i] = d[IW-1:0];
    end

    for (int k = P-1; k >= 1; k--) begin
      take_r = nv[2*k+1] &&
               (!nv[2*k] ||
                (nts[2*k+1] < nts[2*k]) ||
                ((nts[2*k+1] == nts[2*k]) && (npos[2*k+1] < npos[2*k])));
      nv[k]   = take_r ? nv[2*k+1]   : nv[2*k];
      nts[k]  = take_r ? nts[2*k+1]  : nts[2*k];
      nidx[k] = take_r ? nidx[2*k+1] : nidx[2*k];
      npos[k] = take_r ? npos[2*k+1] : npos[2*k];
    end

    grant     = '0;
    any_valid = nv[1];
    min_ts    = nv[1] ? nts[1] : '0;
    if (nv[1]) grant[nidx[1]] = 1'b1;
  end

endmodule

// File: rtl/ttl_event_scheduler.sv
// Merges timestamped TTL event streams into one GPO channel, earliest first,
// with a registered output stage and a sticky out-of-order detector.
module ttl_event_scheduler
  import ttl_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [WORD_W-1:0]         gpo_in,
  output logic                      gpo_valid,
  input  logic                      busy,
  input  logic                      clear_error,
  output logic                      order_error,
  output logic [TS_W-1:0]           error_ts,
  output logic [31:0]               issue_count
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ*TS_W-1:0] req_ts;
  logic [NUM_REQ-1:0]      grant;
  logic                    any_valid;
  logic [TS_W-1:0]         min_ts;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           sel_idx;
  logic [IW-1:0]           rr_next;
  logic [WORD_W-1:0]       sel_word;
  logic [TS_W-1:0]         last_ts;
  logic                    issued_any;
  logic                    load;
  logic                    fire;
  logic                    consume;
  logic                    violation;

  always_comb begin
    req_ts = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ts[i*TS_W +: TS_W] = ts_of(req_data[i*WORD_W +: WORD_W]);
  end

  ttl_min_ts_select #(.NUM_REQ(NUM_REQ)) u_select (
    .valid     (req_valid),
    .ts        (req_ts),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid),
    .min_ts    (min_ts)
  );

  always_comb begin
    sel_idx  = '0;
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx  = i[IW-1:0];
        sel_word = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  assign rr_next   = (sel_idx == IW'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
  assign load      = !gpo_valid || !busy;
  assign fire      = load && any_valid;
  assign consume   = gpo_valid && !busy;
  assign violation = fire && issued_any && (min_ts < last_ts);
  // Gated by reset_n so nothing is handed over while the register cannot load.
  assign req_ready = (load && reset_n) ? grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpo_in     <= '0;
      gpo_valid  <= 1'b0;
      rr_ptr     <= '0;
      last_ts    <= '0;
      issued_any <= 1'b0;
    end else if (fire) begin
      gpo_in     <= sel_word;
      gpo_valid  <= 1'b1;
      rr_ptr     <= rr_next;
      last_ts    <= min_ts;
      issued_any <= 1'b1;
    end else if (consume) begin
      gpo_valid  <= 1'b0;
    end
  end

  // A fresh violation outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      order_error <= 1'b0;
      error_ts    <= '0;
    end else if (violation) begin
      order_error <= 1'b1;
      if (!order_error || clear_error) error_ts <= min_ts;
    end else if (clear_error) begin
      order_error <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     issue_count <= '0;
    else if (consume) issue_count <= issue_count + 32'd1;
  end

endmodule

// File: tb/tb_ttl_event_scheduler.sv
// Scoreboard bench: expected words are queued at grant time and a
// negedge monitor compares them against each consumed gpo_in word.
module tb_ttl_event_scheduler;

  logic         clk;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [511:0] req_data;
  logic [3:0]   req_ready;
  logic [127:0] gpo_in;
  logic         gpo_valid;
  logic         busy;
  logic         clear_error;
  logic         order_error;
  logic [63:0]  error_ts;
  logic [31:0]  issue_count;

  int checks;
  int failures;
  logic [127:0] exp_q[$];
  logic [127:0] sb_exp;

  ttl_event_scheduler #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .gpo_in      (gpo_in),
    .gpo_valid   (gpo_valid),
    .busy        (busy),
    .clear_error (clear_error),
    .order_error (order_error),
    .error_ts    (error_ts),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [63:0] ts, input logic [7:0] tag);
    return {ts, 32'hCAFE_F00D, 24'h0, tag};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // One cycle: drive at posedge+1, check req_ready at negedge, return at posedge+1.
  task automatic applyStimulus(input logic [3:0] valid,
                               input logic [127:0] w0, input logic [127:0] w1,
                               input logic [127:0] w2, input logic [127:0] w3,
                               input logic bsy, input logic clr,
                               input logic [3:0] exp_ready,
                               input bit push, input logic [127:0] exp_word);
    req_valid   = valid;
    req_data    = {w3, w2, w1, w0};
    busy        = bsy;
    clear_error = clr;
    if (push) exp_q.push_back(exp_word);
    @(negedge clk);
    checkOutput("req_ready", {124'h0, req_ready}, {124'h0, exp_ready});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic clr);
    applyStimulus(4'b0000, '0, '0, '0, '0, 1'b0, clr, 4'b0000, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && gpo_valid === 1'b1 && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL gpo_word actual=%h required=no_word", gpo_in);
      end else begin
        sb_exp = exp_q.pop_front();
        checkOutput("gpo_word", gpo_in, sb_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    busy        = 1'b0;
    clear_error = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_gpo_valid", {127'h0, gpo_valid}, 128'h0);
    checkOutput("rst_gpo_in", gpo_in, 128'h0);
    checkOutput("rst_req_ready", {124'h0, req_ready}, 128'h0);
    checkOutput("rst_order_error", {127'h0, order_error}, 128'h0);
    checkOutput("rst_error_ts", {64'h0, error_ts}, 128'h0);
    checkOutput("rst_issue_count", {96'h0, issue_count}, 128'h0);
    reset_n = 1'b1;

    $display("[TB] equal timestamps, round-robin");
    applyStimulus(4'hF, mk(7, 8'h00), mk(7, 8'h01), mk(7, 8'h02), mk(7, 8'h03),
                  1'b0, 1'b0, 4'b0001, 1'b1, mk(7, 8'h00));
    applyStimulus(4'hF, mk(7, 8'h00), mk(7, 8'h01), mk(7, 8'h02), mk(7, 8'h03),
                  1'b0, 1'b0, 4'b0010, 1'b1, mk(7, 8'h01));
    applyStimulus(4'hF, mk(7, 8'h00), mk(7, 8'h01), mk(7, 8'h02), mk(7, 8'h03),
                  1'b0, 1'b0, 4'b0100, 1'b1, mk(7, 8'h02));
    applyStimulus(4'hF, mk(7, 8'h00), mk(7, 8'h01), mk(7, 8'h02), mk(7, 8'h03),
                  1'b0, 1'b0, 4'b1000, 1'b1, mk(7, 8'h03));
    applyStimulus(4'hF, mk(7, 8'h00), mk(7, 8'h01), mk(7, 8'h02), mk(7, 8'h03),
                  1'b0, 1'b0, 4'b0001, 1'b1, mk(7, 8'h00));
    idle(1'b0);
    checkOutput("count_rr", {96'h0, issue_count}, 128'd5);

    $display("[TB] earliest timestamp first");
    applyStimulus(4'b0101, mk(100, 8'h10), '0, mk(50, 8'h12), '0,
                  1'b0, 1'b0, 4'b0100, 1'b1, mk(50, 8'h12));
    applyStimulus(4'b0001, mk(100, 8'h10), '0, '0, '0,
                  1'b0, 1'b0, 4'b0001, 1'b1, mk(100, 8'h10));
    idle(1'b0);
    checkOutput("count_min", {96'h0, issue_count}, 128'd7);
    checkOutput("drained_valid", {127'h0, gpo_valid}, 128'h0);
    checkOutput("drained_hold", gpo_in, mk(100, 8'h10));

    $display("[TB] busy stall");
    applyStimulus(4'b0010, '0, mk(110, 8'h21), '0, '0,
                  1'b0, 1'b0, 4'b0010, 1'b1, mk(110, 8'h21));
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b1000, '0, '0, '0, mk(120, 8'h23),
                    1'b1, 1'b0, 4'b0000, 1'b0, '0);
      checkOutput("stall_word", gpo_in, mk(110, 8'h21));
      checkOutput("stall_count", {96'h0, issue_count}, 128'd7);
    end
    applyStimulus(4'b1000, '0, '0, '0, mk(120, 8'h23),
                  1'b0, 1'b0, 4'b1000, 1'b1, mk(120, 8'h23));
    checkOutput("release_count", {96'h0, issue_count}, 128'd8);
    idle(1'b0);

    $display("[TB] order check");
    applyStimulus(4'b0001, mk(200, 8'h30), '0, '0, '0,
                  1'b0, 1'b0, 4'b0001, 1'b1, mk(200, 8'h30));
    checkOutput("in_order_err", {127'h0, order_error}, 128'h0);
    applyStimulus(4'b0010, '0, mk(150, 8'h31), '0, '0,
                  1'b0, 1'b0, 4'b0010, 1'b1, mk(150, 8'h31));
    checkOutput("viol_err", {127'h0, order_error}, 128'h1);
    checkOutput("viol_ts", {64'h0, error_ts}, 128'd150);
    applyStimulus(4'b0100, '0, '0, mk(120, 8'h32), '0,
                  1'b0, 1'b0, 4'b0100, 1'b1, mk(120, 8'h32));
    checkOutput("second_viol_err", {127'h0, order_error}, 128'h1);
    checkOutput("second_viol_ts", {64'h0, error_ts}, 128'd150);
    idle(1'b1);
    checkOutput("cleared_err", {127'h0, order_error}, 128'h0);
    applyStimulus(4'b1000, '0, '0, '0, mk(100, 8'h33),
                  1'b0, 1'b1, 4'b1000, 1'b1, mk(100, 8'h33));
    checkOutput("clr_vs_viol_err", {127'h0, order_error}, 128'h1);
    checkOutput("clr_vs_viol_ts", {64'h0, error_ts}, 128'd100);
    idle(1'b0);
    checkOutput("count_order", {96'h0, issue_count}, 128'd13);

    $display("[TB] reset while holding");
    applyStimulus(4'b0001, mk(300, 8'h40), '0, '0, '0,
                  1'b1, 1'b0, 4'b0001, 1'b0, '0);
    checkOutput("held_valid", {127'h0, gpo_valid}, 128'h1);
    req_valid = 4'b0001;
    req_data  = {384'h0, mk(310, 8'h41)};
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_gpo_valid", {127'h0, gpo_valid}, 128'h0);
    checkOutput("mid_rst_gpo_in", gpo_in, 128'h0);
    checkOutput("mid_rst_req_ready", {124'h0, req_ready}, 128'h0);
    checkOutput("mid_rst_order_error", {127'h0, order_error}, 128'h0);
    checkOutput("mid_rst_error_ts", {64'h0, error_ts}, 128'h0);
    checkOutput("mid_rst_issue_count", {96'h0, issue_count}, 128'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(4'b0010, '0, mk(0, 8'h42), '0, '0,
                  1'b0, 1'b0, 4'b0010, 1'b1, mk(0, 8'h42));
    checkOutput("post_rst_err", {127'h0, order_error}, 128'h0);
    idle(1'b0);
    checkOutput("post_rst_count", {96'h0, issue_count}, 128'd1);
    idle(1'b0);
    checkOutput("queue_empty", 128'(exp_q.size()), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
